// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   XLEN          : datapath width, fixed at 64
//   F3_*          : RV64I funct3 encodings for loads and stores
//   lsu_state_t   : FSM state encoding for the top-level sequencer
//   access_fault  : misalignment / illegal-funct3 check applied at accept
package lsu_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LDDATA,
    S_WR,
    S_RESP
  } lsu_state_t;

  // funct3[1:0] is the access size for both signed and unsigned loads, so
  // the alignment rule only needs those two bits.
  function automatic logic access_fault(input logic       write,
                                        input logic [2:0] f3,
                                        input logic [2:0] off);
    logic misaligned;
    logic illegal;
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off[1:0] != 2'b00);
      default: misaligned = (off != 3'b000);
    endcase
    illegal = write ? f3[2] : (f3 == 3'b111);
    return misaligned || illegal;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic for the load/store unit.
//   rdata      in  : doubleword read from memory
//   wdata      in  : store data (low bytes used)
//   offset     in  : byte offset within the doubleword (addr[2:0])
//   funct3     in  : RV64I funct3 of the access
//   ext_data   out : load lane, sign- or zero-extended to XLEN
//   merge_data out : rdata with the store lane replaced by wdata
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_data,
  output logic [XLEN-1:0] merge_data
);

  logic [5:0]      sh;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;

  always_comb begin
    sh   = {offset, 3'b000};
    // Little-endian: bringing the addressed byte down to bit 0 puts the
    // whole lane in the low bits.
    lane = rdata >> sh;

    case (funct3)
      F3_B:    ext_data = {{56{lane[7]}}, lane[7:0]};
      F3_H:    ext_data = {{48{lane[15]}}, lane[15:0]};
      F3_W:    ext_data = {{32{lane[31]}}, lane[31:0]};
      F3_D:    ext_data = lane;
      F3_BU:   ext_data = {56'd0, lane[7:0]};
      F3_HU:   ext_data = {48'd0, lane[15:0]};
      F3_WU:   ext_data = {32'd0, lane[31:0]};
      default: ext_data = '0;
    endcase

    case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase

    merge_data = (rdata & ~(mask << sh)) | ((wdata & mask) << sh);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage between the control FSM and a 64-bit doubleword
// data memory. Loads are extracted and extended per funct3; sub-doubleword
// stores are done as read-modify-write through a merge buffer.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_write/funct3/addr/wdata: request fields, captured at accept
//   resp_valid/rdata/fault     : one-cycle completion pulse and result
//   mem_read/mem_write         : one-cycle memory strobes
//   mem_addr/mem_wdata         : doubleword-aligned address, write data
//   mem_rdata                  : read data, valid the cycle after mem_read
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t state, state_nxt;

  logic            write_q;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;
  logic [AW-1:3]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  logic            accept;
  logic            req_fault;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] merge_data;

  lsu_byte_lane u_lane (
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .offset     (off_q),
    .funct3     (f3_q),
    .ext_data   (ext_data),
    .merge_data (merge_data)
  );

  assign accept    = (state == S_IDLE) && req_valid;
  assign req_fault = access_fault(req_write, req_funct3, req_addr[2:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault)                             state_nxt = S_RESP;
          else if (req_write && req_funct3 == F3_D)  state_nxt = S_WR;
          else                                       state_nxt = S_RD;
        end
      end
      S_RD:     state_nxt = S_LDDATA;
      S_LDDATA: state_nxt = write_q ? S_WR : S_RESP;
      S_WR:     state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr[AW-1:3];
        rdata_q <= '0;
        fault_q <= req_fault;
      end else if (state == S_LDDATA && !write_q) begin
        rdata_q <= ext_data;
      end
    end
  end

  // Request payload and merge buffer are pure data: they are only consumed
  // in states that are reached after being written, so they need no reset.
  // SD preloads the buffer with the full store data and skips the read.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      f3_q    <= req_funct3;
      off_q   <= req_addr[2:0];
      wdata_q <= req_wdata;
      buf_q   <= req_wdata;
    end else if (state == S_LDDATA && write_q) begin
      buf_q <= merge_data;
    end
  end

  // Strobes decode straight from state, so a reset that returns the FSM to
  // IDLE also kills any write that an interrupted store was heading for.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_fault = (state == S_RESP) && fault_q;
  assign resp_rdata = rdata_q;
  assign mem_read   = (state == S_RD);
  assign mem_write  = (state == S_WR);
  assign mem_addr   = {addr_q, 3'b000};
  assign mem_wdata  = (state == S_WR) ? buf_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int wr_total = 0;

  logic        preload;
  logic [63:0] mem [0:7];

  load_store_unit #(.AW(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Doubleword memory: 8 entries, read data registered one cycle after mem_read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'h0;
      mem[2] <= 64'h8877665544332211;
      mem_rdata <= 64'h0;
    end else begin
      if (mem_write) begin
        mem[mem_addr[5:3]] <= mem_wdata;
        wr_total <= wr_total + 1;
      end
      if (mem_read) mem_rdata <= mem[mem_addr[5:3]];
    end
  end

  // Issues one request and observes it to completion. Cycle c is the period
  // following the c-th rising edge after the accept edge (cycle 0).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input bit no_wait,
                        output int resp_cyc, output logic [63:0] rdata, output logic fault,
                        output int rd_cnt, output int rd_cyc, output logic [63:0] rd_addr,
                        output int wr_cnt, output int wr_cyc, output logic [63:0] wr_data,
                        output logic both, output logic post_ok);
    if (!no_wait) @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    // Scramble the inputs right after accept; the captured request must win.
    req_write = ~w; req_funct3 = 3'b011; req_addr = 64'h28; req_wdata = '1;
    resp_cyc = -1; rdata = 'x; fault = 1'bx; rd_cnt = 0; rd_cyc = -1; rd_addr = 'x;
    wr_cnt = 0; wr_cyc = -1; wr_data = 'x; both = 1'b0;
    for (int c = 1; c <= 10 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 2) req_valid = 1'b0;
      if (mem_read)  begin rd_cnt++; rd_cyc = c; rd_addr = mem_addr; end
      if (mem_write) begin wr_cnt++; wr_cyc = c; wr_data = mem_wdata; end
      if (mem_read && mem_write) both = 1'b1;
      if (resp_valid) begin resp_cyc = c; rdata = resp_rdata; fault = resp_fault; end
    end
    @(negedge clk);
    req_valid = 1'b0;
    post_ok = !resp_valid && req_ready && !mem_read && !mem_write;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; preload = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_fault, mem_read, mem_write} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {req_ready, resp_valid, resp_fault, mem_read, mem_write});
    end
    n_vec++;
    if ((resp_rdata | mem_addr | mem_wdata) !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want all 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    preload = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] exp, input bit no_wait);
    int rc, rdc, rdn, wrc, wrn; logic [63:0] rd, ra, wd; logic flt, both, pok;
    do_req(1'b0, f3, addr, 64'h0, no_wait, rc, rd, flt, rdn, rdc, ra, wrn, wrc, wd, both, pok);
    n_vec++;
    if (rc !== 3) begin n_err++; $display("FAIL %s_resp_cycle: got %0d want 3", nm, rc); end
    n_vec++;
    if (rd !== exp || flt !== 1'b0) begin
      n_err++; $display("FAIL %s_data: got %h fault=%b want %h fault=0", nm, rd, flt, exp);
    end
    n_vec++;
    if (rdn !== 1 || rdc !== 1 || wrn !== 0 || ra !== {addr[63:3], 3'b000}) begin
      n_err++;
      $display("FAIL %s_mem: reads=%0d@%0d addr=%h writes=%0d want 1@1 addr=%h writes=0",
               nm, rdn, rdc, ra, wrn, {addr[63:3], 3'b000});
    end
    n_vec++;
    if (!pok || both) begin n_err++; $display("FAIL %s_post: idle_ok=%b both=%b want 1/0", nm, pok, both); end
  endtask

  task automatic test_store_sub(input string nm, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_wr);
    int rc, rdc, rdn, wrc, wrn; logic [63:0] rd, ra, wd; logic flt, both, pok;
    do_req(1'b1, f3, addr, wdata, 1'b0, rc, rd, flt, rdn, rdc, ra, wrn, wrc, wd, both, pok);
    n_vec++;
    if (rc !== 4 || flt !== 1'b0 || rd !== 64'h0) begin
      n_err++; $display("FAIL %s_resp: cycle=%0d fault=%b rdata=%h want 4/0/0", nm, rc, flt, rd);
    end
    n_vec++;
    if (rdn !== 1 || rdc !== 1 || wrn !== 1 || wrc !== 3) begin
      n_err++; $display("FAIL %s_strobes: rd=%0d@%0d wr=%0d@%0d want 1@1 1@3", nm, rdn, rdc, wrn, wrc);
    end
    n_vec++;
    if (wd !== exp_wr) begin n_err++; $display("FAIL %s_wdata: got %h want %h", nm, wd, exp_wr); end
    n_vec++;
    if (!pok || both) begin n_err++; $display("FAIL %s_post: idle_ok=%b both=%b want 1/0", nm, pok, both); end
  endtask

  task automatic test_store_d;
    int rc, rdc, rdn, wrc, wrn; logic [63:0] rd, ra, wd; logic flt, both, pok;
    do_req(1'b1, 3'b011, 64'h18, 64'h0123456789ABCDEF, 1'b0,
           rc, rd, flt, rdn, rdc, ra, wrn, wrc, wd, both, pok);
    n_vec++;
    if (rc !== 2 || flt !== 1'b0) begin
      n_err++; $display("FAIL sd_resp: cycle=%0d fault=%b want 2/0", rc, flt);
    end
    n_vec++;
    if (rdn !== 0 || wrn !== 1 || wrc !== 1 || wd !== 64'h0123456789ABCDEF) begin
      n_err++;
      $display("FAIL sd_mem: reads=%0d writes=%0d@%0d wdata=%h want 0 1@1 0123456789abcdef",
               rdn, wrn, wrc, wd);
    end
    n_vec++;
    if (!pok) begin n_err++; $display("FAIL sd_post: idle_ok=%b want 1", pok); end
  endtask

  task automatic test_fault(input string nm, input logic w, input logic [2:0] f3,
                            input logic [63:0] addr);
    int rc, rdc, rdn, wrc, wrn; logic [63:0] rd, ra, wd; logic flt, both, pok;
    do_req(w, f3, addr, 64'hAAAA_5555_AAAA_5555, 1'b0,
           rc, rd, flt, rdn, rdc, ra, wrn, wrc, wd, both, pok);
    n_vec++;
    if (rc !== 1 || flt !== 1'b1 || rd !== 64'h0) begin
      n_err++; $display("FAIL %s_resp: cycle=%0d fault=%b rdata=%h want 1/1/0", nm, rc, flt, rd);
    end
    n_vec++;
    if (rdn !== 0 || wrn !== 0 || !pok) begin
      n_err++; $display("FAIL %s_strobes: reads=%0d writes=%0d idle_ok=%b want 0/0/1", nm, rdn, wrn, pok);
    end
  endtask

  task automatic test_reset_midop;
    int w0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 64'h10; req_wdata = 64'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w0 = wr_total;
    @(negedge clk);            // cycle 1: RD
    @(negedge clk);            // cycle 2: LDDATA
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_fault, mem_read, mem_write} !== 5'b10000 ||
        (resp_rdata | mem_addr | mem_wdata) !== 64'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: ctrl=%b rdata=%h addr=%h wdata=%h want 10000/0/0/0",
               {req_ready, resp_valid, resp_fault, mem_read, mem_write}, resp_rdata, mem_addr, mem_wdata);
    end
    // Reset and a request on the same edge: the request must be dropped.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (mem_read !== 1'b0 || req_ready !== 1'b1 || wr_total !== w0) begin
      n_err++;
      $display("FAIL midreset_drop: mem_read=%b ready=%b writes=%0d want 0/1/%0d",
               mem_read, req_ready, wr_total, w0);
    end
    test_load("ld_after_reset", 3'b011, 64'h10, 64'h8877665544332211, 1'b0);
  endtask

  task automatic test_back_to_back;
    test_load("b2b_first", 3'b011, 64'h18, 64'h0123456789ABCDEF, 1'b0);
    test_load("b2b_second", 3'b100, 64'h17, 64'h0000000000000088, 1'b1);
  endtask

  initial begin
    test_reset;
    test_load("lb", 3'b000, 64'h17, 64'hFFFFFFFFFFFFFF88, 1'b0);
    test_load("lhu", 3'b101, 64'h12, 64'h0000000000004433, 1'b0);
    test_load("lw", 3'b010, 64'h14, 64'hFFFFFFFF88776655, 1'b0);
    test_load("lwu", 3'b110, 64'h14, 64'h0000000088776655, 1'b0);
    test_load("lh_neg", 3'b001, 64'h16, 64'hFFFFFFFFFFFF8877, 1'b0);
    test_fault("lw_misalign", 1'b0, 3'b010, 64'h12);
    test_fault("ld_f3_111", 1'b0, 3'b111, 64'h10);
    test_fault("st_f3_100", 1'b1, 3'b100, 64'h10);
    test_fault("sd_misalign", 1'b1, 3'b011, 64'h14);
    test_store_d;
    test_load("ld_sd_back", 3'b011, 64'h18, 64'h0123456789ABCDEF, 1'b0);
    test_reset_midop;
    test_back_to_back;
    test_store_sub("sb", 3'b000, 64'h11, 64'h00000000000000AB, 64'h887766554433AB11);
    test_load("ld_sb_back", 3'b011, 64'h10, 64'h887766554433AB11, 1'b0);
    test_store_sub("sw", 3'b010, 64'h14, 64'hFFFFFFFFCAFEF00D, 64'hCAFEF00D4433AB11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the ALU/control FSM and the 64-bit doubleword data memory of the multicycle RISC-V datapath. It accepts one load or store request per memory cycle and drives the doubleword-aligned memory port. Sub-doubleword stores are performed as a read-modify-write. Load data is extracted per RV64I funct3 (sign- or zero-extended) and returned to the write-back path with a fault flag for misaligned or illegal accesses.

## Interface
- XLEN, 64, data width; fixed at 64.
- AW, 64, address width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request strobe from the control FSM.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64I funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- req_addr  in  AW  byte address (ALU result).
- req_wdata  in  XLEN  store data (rs2), low bytes used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  AW  {req_addr[AW-1:3], 3'b000}.
- mem_wdata  out  XLEN  full doubleword to write.
- mem_rdata  in  XLEN  read data; valid the cycle after mem_read.

## Operation
- States: IDLE, RD, LDDATA, WR, RESP.
- IDLE accepts when req_valid=1.
  - All request fields are captured at accept. Later input changes are ignored until the unit returns to IDLE.
  - req_valid while not in IDLE is ignored; it is not queued.
- Fault check at accept:
  - H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
  - Illegal funct3: load 111, or store with funct3[2]=1.
  - On fault: IDLE→RESP with resp_fault=1; no mem strobe is ever issued.
- Load path: IDLE→RD (mem_read=1) →LDDATA (register the extracted lane into resp_rdata) →RESP.
- SD: IDLE→WR (mem_write=1, mem_wdata=req_wdata) →RESP. No read is issued.
- SB/SH/SW: IDLE→RD→LDDATA→WR→RESP.
  - LDDATA merges the low 8/16/32 bits of req_wdata into mem_rdata at byte offset addr[2:0]. The merged doubleword is held in a 64-bit buffer.
  - WR drives the buffer onto mem_wdata.
- RESP: resp_valid=1 for exactly one cycle, then →IDLE.
  - resp has no backpressure; the consumer must sample it in that cycle.
- Lane rules:
  - Little-endian; lane = addr[2:0]×8 bits.
  - Signed loads replicate the lane MSB up to bit 63; LBU/LHU/LWU zero-fill.
- mem_read and mem_write are never both high. Each strobe is high for exactly one cycle per request.

## Timing
- Accept edge = cycle 0. resp_valid is high in:
  - Fault: cycle 1.
  - SD: cycle 2.
  - Loads: cycle 3.
  - SB/SH/SW: cycle 4.
- Back-to-back: the next request can be accepted the cycle after RESP (IDLE).
- Reset values: state IDLE.
  - req_ready=1.
  - resp_valid, resp_fault, mem_read, mem_write = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
- Reset mid-operation (any state): next edge → IDLE with reset values.
  - No mem_write is issued in the cycle after reset.
  - An interrupted partial store leaves memory unmodified.
- rst_n and req_valid together: reset wins; the request is dropped.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - State enum lsu_state_t.
  - XLEN localparam.
- One combinational sub-module, lsu_byte_lane, is natural. It provides:
  - extract(rdata, offset, funct3) → extended value.
  - merge(rdata, wdata, offset, funct3) → doubleword.
- The top level holds the FSM, request capture registers and merge buffer.

## Test plan
Memory model: doubleword at 0x10 = 0x8877665544332211; mem_rdata returned one cycle after mem_read.
- LB 0x17 → resp_rdata=0xFFFFFFFFFFFFFF88 in cycle 3; one mem_read; mem_addr=0x10.
- LHU 0x12 → 0x0000000000004433. LW 0x14 → 0xFFFFFFFF88776655. LWU 0x14 → 0x0000000088776655.
- SB 0x11, wdata=0x...AB → mem_read in cycle 1; mem_write in cycle 3 with mem_wdata=0x887766554433AB11; resp_valid in cycle 4.
- SD 0x18, wdata=0x0123456789ABCDEF → no mem_read; mem_write in cycle 1; resp_valid in cycle 2 with resp_fault=0.
- LW 0x12 and load funct3=111 → resp_fault=1 in cycle 1; mem_read and mem_write stay 0 throughout.
- SH 0x10 with rst_n=0 asserted during LDDATA → no mem_write; all outputs at reset values; a following LD 0x10 returns 0x8877665544332211.
